// File: rtl/uart_cmd_decoder_if.sv
// Bus between the command decoder and its neighbours (UART rx/tx, register block).
// master: the decoder side. It takes rx bytes, read data and tx busy, and drives
//         command, addresses, write data/strobe, tx byte/start, busy and err.
// slave:  the environment side, which is the mirror image of master.
interface uart_cmd_decoder_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADR_W  = 16;

    logic [BYTE_W-1:0] rx_byte;
    logic              ce_rx;
    logic [BYTE_W-1:0] my_dat;
    logic              tx_busy;
    logic [BYTE_W-1:0] com;
    logic [ADR_W-1:0]  wr_adr;
    logic [ADR_W-1:0]  rd_adr;
    logic [BYTE_W-1:0] rx_dat;
    logic              ce_wr_dat;
    logic [BYTE_W-1:0] tx_dat;
    logic              st_tx;
    logic              busy;
    logic              err;

    modport master (
        input  rx_byte, ce_rx, my_dat, tx_busy,
        output com, wr_adr, rd_adr, rx_dat, ce_wr_dat, tx_dat, st_tx, busy, err
    );

    modport slave (
        output rx_byte, ce_rx, my_dat, tx_busy,
        input  com, wr_adr, rd_adr, rx_dat, ce_wr_dat, tx_dat, st_tx, busy, err
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART command-frame decoder.
// The frame format is SYNC, COM, ADR_HI, ADR_LO, LEN, followed by LEN+1 data
// bytes on write frames only.
// - Write frames (com[7]=0) produce one write strobe per data byte, at
//   incrementing addresses.
// - Read frames (com[7]=1) step rd_adr and send each returned byte to the
//   transmitter.
// Ports:
// - clk, rst: clock and synchronous active-high reset.
// - bus (master): rx_byte/ce_rx in; my_dat in; tx_busy in.
//   com/wr_adr/rd_adr/rx_dat/ce_wr_dat out to the register block.
//   tx_dat/st_tx out to the transmitter; busy/err out as status.
module uart_cmd_decoder #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned RD_LAT  = 1,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_decoder_if.master  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADR_W  = 16;
    localparam int unsigned LAT_W  = 3;

    typedef enum logic [3:0] {
        IDLE, COM, AH, AL, LEN, WDAT, RADR, RSEND, RHOLD
    } state_t;

    state_t            state, state_d;
    logic [BYTE_W-1:0] com_q, com_d;
    logic [ADR_W-1:0]  base_q, base_d;       // next address to use
    logic [BYTE_W-1:0] cnt_q, cnt_d;         // LEN byte
    logic [BYTE_W-1:0] idx_q, idx_d;         // current transfer index i
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              first_q, first_d;     // first RHOLD cycle, tx_busy ignored
    logic [ADR_W-1:0]  tmo_q, tmo_d;
    logic [ADR_W-1:0]  wr_adr_q, wr_adr_d;
    logic [ADR_W-1:0]  rd_adr_q, rd_adr_d;
    logic [BYTE_W-1:0] rx_dat_q, rx_dat_d;
    logic [BYTE_W-1:0] tx_dat_q, tx_dat_d;
    logic              ce_wr_q, ce_wr_d;
    logic              st_tx_q, st_tx_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              timed;
    logic              expired;
    logic              accept;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            com_q    <= 8'hFF;
            base_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
            first_q  <= 1'b0;
            tmo_q    <= '0;
            wr_adr_q <= '0;
            rd_adr_q <= '0;
            rx_dat_q <= '0;
            tx_dat_q <= '0;
            ce_wr_q  <= 1'b0;
            st_tx_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            com_q    <= com_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            first_q  <= first_d;
            tmo_q    <= tmo_d;
            wr_adr_q <= wr_adr_d;
            rd_adr_q <= rd_adr_d;
            rx_dat_q <= rx_dat_d;
            tx_dat_q <= tx_dat_d;
            ce_wr_q  <= ce_wr_d;
            st_tx_q  <= st_tx_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        com_d    = com_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        first_d  = first_q;
        tmo_d    = '0;
        wr_adr_d = wr_adr_q;
        rd_adr_d = rd_adr_q;
        rx_dat_d = rx_dat_q;
        tx_dat_d = tx_dat_q;
        ce_wr_d  = 1'b0;
        st_tx_d  = 1'b0;
        err_d    = 1'b0;

        timed   = (state == COM) || (state == AH) || (state == AL) ||
                  (state == LEN) || (state == WDAT);
        expired = timed && (tmo_q == TIMEOUT - 16'd1);
        // A byte arriving on the expiry cycle is dropped.
        accept  = bus.ce_rx && !expired;

        if (timed) begin
            tmo_d = accept ? '0 : tmo_q + 16'd1;
        end

        case (state)
            IDLE: begin
                if (bus.ce_rx && (bus.rx_byte == SYNC)) begin
                    state_d = COM;
                end
            end
            COM: begin
                if (accept) begin
                    com_d   = bus.rx_byte;
                    state_d = AH;
                end
            end
            AH: begin
                if (accept) begin
                    base_d[15:8] = bus.rx_byte;
                    state_d      = AL;
                end
            end
            AL: begin
                if (accept) begin
                    base_d[7:0] = bus.rx_byte;
                    state_d     = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    cnt_d = bus.rx_byte;
                    idx_d = '0;
                    lat_d = '0;
                    if (com_q[7]) begin
                        rd_adr_d = base_q;
                        state_d  = RADR;
                    end else begin
                        state_d  = WDAT;
                    end
                end
            end
            WDAT: begin
                if (accept) begin
                    wr_adr_d = base_q;
                    rx_dat_d = bus.rx_byte;
                    ce_wr_d  = 1'b1;
                    base_d   = base_q + 16'd1;
                    if (idx_q == cnt_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            RADR: begin
                // rd_adr has been stable for RD_LAT cycles once lat reaches RD_LAT.
                if (lat_q == LAT_W'(RD_LAT)) begin
                    tx_dat_d = bus.my_dat;
                    state_d  = RSEND;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RSEND: begin
                if (!bus.tx_busy) begin
                    st_tx_d = 1'b1;
                    first_d = 1'b1;
                    state_d = RHOLD;
                end
            end
            RHOLD: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    if (idx_q == cnt_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + 8'd1;
                        rd_adr_d = rd_adr_q + 16'd1;
                        lat_d    = '0;
                        state_d  = RADR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.com       = com_q;
    assign bus.wr_adr    = wr_adr_q;
    assign bus.rd_adr    = rd_adr_q;
    assign bus.rx_dat    = rx_dat_q;
    assign bus.ce_wr_dat = ce_wr_q;
    assign bus.tx_dat    = tx_dat_q;
    assign bus.st_tx     = st_tx_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule
